// File: rtl/efpga_dispatch.sv
// efpga_dispatch: decodes eFPGA custom instructions and runs the
// valid/ready exchange with one fabric channel, with optional writeback.
module efpga_dispatch #(
    parameter int NB_CHANNELS    = 4,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        p_clk,
    input  logic                        p_reset,
    input  logic [31:0]                 p_instr,
    input  logic                        p_instr_valid,
    input  logic [XLEN-1:0]             p_rs1,
    input  logic [XLEN-1:0]             p_rs2,
    output logic                        p_is_efpga,
    output logic                        p_illegal,
    output logic                        p_stall,
    output logic                        p_rd_we,
    output logic [4:0]                  p_rd_addr,
    output logic [XLEN-1:0]             p_rd_data,
    output logic                        p_timeout,
    input  logic                        p_timeout_clr,
    output logic [NB_CHANNELS-1:0]      p_fab_req_valid,
    input  logic [NB_CHANNELS-1:0]      p_fab_req_ready,
    output logic [XLEN-1:0]             p_fab_op1,
    output logic [XLEN-1:0]             p_fab_op2,
    output logic                        p_fab_blocking,
    input  logic [NB_CHANNELS-1:0]      p_fab_rsp_valid,
    input  logic [NB_CHANNELS*XLEN-1:0] p_fab_rsp_data,
    output logic [NB_CHANNELS-1:0]      p_fab_rsp_ready
);

    localparam int CHW = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1;
    localparam int CW  = (TIMEOUT_CYCLES < 2) ? 1
                       : $clog2(TIMEOUT_CYCLES + 1);
    localparam int TLIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CW-1:0] TLIM_C = CW'(TLIM);
    localparam logic [NB_CHANNELS-1:0] ONE = NB_CHANNELS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CHW-1:0]         ch_q;
    logic [4:0]             rd_q;
    logic                   blk_q;
    logic [XLEN-1:0]        data_q;
    logic [CW-1:0]          cnt_q;
    logic [NB_CHANNELS-1:0] req_q;
    logic [NB_CHANNELS-1:0] ch_oh;
    logic [XLEN-1:0]        rsp_sel;
    logic [6:0]             funct7;
    logic [2:0]             funct3;
    logic                   legal;
    logic                   accept;
    logic                   rsp_hit;
    logic                   tmo_hit;
    logic                   tmo_set;
    logic                   unused_ok;

    assign funct7 = p_instr[31:25];
    assign funct3 = p_instr[14:12];
    assign unused_ok = ^p_instr[24:15];

    assign p_is_efpga = p_instr_valid
                     && (p_instr[6:0] == 7'b1110011)
                     && (funct3[2:1] == 2'b11);
    assign legal = p_is_efpga && (funct7 < 7'(NB_CHANNELS));
    assign p_illegal = (state_q == S_IDLE) && p_is_efpga && !legal;

    assign ch_oh   = ONE << ch_q;
    assign accept  = |(req_q & p_fab_req_ready);
    assign rsp_hit = |(p_fab_rsp_valid & ch_oh);
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TLIM_C);

    assign p_fab_req_valid = req_q;
    assign p_fab_blocking  = blk_q;
    assign p_rd_addr       = rd_q;
    assign p_rd_data       = data_q;

    // Select the response word of the latched channel
    always_comb begin
        rsp_sel = '0;
        for (int c = 0; c < NB_CHANNELS; c++) begin
            if (ch_q == CHW'(c)) rsp_sel = p_fab_rsp_data[c*XLEN +: XLEN];
        end
    end

    // State register
    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state, stall, writeback strobe and response-ready steering
    always_comb begin
        state_d         = state_q;
        tmo_set         = 1'b0;
        p_stall         = 1'b0;
        p_rd_we         = 1'b0;
        p_fab_rsp_ready = '1;
        unique case (state_q)
            S_IDLE: begin
                if (legal) begin
                    p_stall = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                p_stall = 1'b1;
                if (accept) begin
                    state_d = blk_q ? S_WAIT : S_IDLE;
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    state_d = blk_q ? S_DONE : S_IDLE;
                end
            end
            S_WAIT: begin
                p_stall         = 1'b1;
                p_fab_rsp_ready = ch_oh;
                if (rsp_hit) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                p_rd_we = (rd_q != 5'd0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, operands, timeout counter, result and sticky flag
    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            ch_q      <= '0;
            rd_q      <= '0;
            blk_q     <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
            req_q     <= '0;
            p_fab_op1 <= '0;
            p_fab_op2 <= '0;
            p_timeout <= 1'b0;
        end else begin
            if (state_q == S_IDLE && legal) begin
                ch_q      <= funct7[CHW-1:0];
                rd_q      <= p_instr[11:7];
                blk_q     <= ~funct3[0];
                p_fab_op1 <= p_rs1;
                p_fab_op2 <= p_rs2;
                req_q     <= ONE << funct7;
                cnt_q     <= '0;
            end
            if (state_q == S_ISSUE && (accept || tmo_hit)) req_q <= '0;
            if (state_q == S_ISSUE || state_q == S_WAIT) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (state_q == S_WAIT && rsp_hit) data_q <= rsp_sel;
            else if (tmo_set)                 data_q <= '1;
            if (p_timeout_clr) p_timeout <= 1'b0;
            else if (tmo_set)  p_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_efpga_dispatch.sv
// tb_efpga_dispatch: scenario tasks drive instructions and fabric;
// a writeback monitor compares rd writes against a scoreboard queue.
module tb_efpga_dispatch;

    localparam int NB = 4;
    localparam int XL = 32;

    logic           p_clk = 1'b0;
    logic           p_reset;
    logic [31:0]    p_instr;
    logic           p_instr_valid;
    logic [XL-1:0]  p_rs1, p_rs2;
    logic           p_is_efpga, p_illegal, p_stall, p_rd_we;
    logic [4:0]     p_rd_addr;
    logic [XL-1:0]  p_rd_data;
    logic           p_timeout, p_timeout_clr;
    logic [NB-1:0]  p_fab_req_valid, p_fab_req_ready;
    logic [XL-1:0]  p_fab_op1, p_fab_op2;
    logic           p_fab_blocking;
    logic [NB-1:0]  p_fab_rsp_valid, p_fab_rsp_ready;
    logic [NB*XL-1:0] p_fab_rsp_data;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    efpga_dispatch #(
        .NB_CHANNELS(NB), .XLEN(XL), .TIMEOUT_CYCLES(8)
    ) dut (
        .p_clk(p_clk), .p_reset(p_reset),
        .p_instr(p_instr), .p_instr_valid(p_instr_valid),
        .p_rs1(p_rs1), .p_rs2(p_rs2),
        .p_is_efpga(p_is_efpga), .p_illegal(p_illegal),
        .p_stall(p_stall), .p_rd_we(p_rd_we),
        .p_rd_addr(p_rd_addr), .p_rd_data(p_rd_data),
        .p_timeout(p_timeout), .p_timeout_clr(p_timeout_clr),
        .p_fab_req_valid(p_fab_req_valid),
        .p_fab_req_ready(p_fab_req_ready),
        .p_fab_op1(p_fab_op1), .p_fab_op2(p_fab_op2),
        .p_fab_blocking(p_fab_blocking),
        .p_fab_rsp_valid(p_fab_rsp_valid),
        .p_fab_rsp_data(p_fab_rsp_data),
        .p_fab_rsp_ready(p_fab_rsp_ready)
    );

    always #5 p_clk = ~p_clk;

    // Every rd write must match the oldest expected writeback
    always @(negedge p_clk) begin
        if (!p_reset && p_rd_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: rd=%0d data=%h, none required",
                         p_rd_addr, p_rd_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({p_rd_addr, p_rd_data} !== e) begin
                    errors++;
                    $display("FAIL wb_data: got rd=%0d data=%h, need rd=%0d data=%h",
                             p_rd_addr, p_rd_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    function automatic logic [31:0] enc(input logic [6:0] f7,
                                        input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b1110011};
    endfunction

    task automatic tick();
        @(posedge p_clk);
        #2;
    endtask

    task automatic issue(input logic [6:0] f7, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b);
        p_instr       = enc(f7, f3, rd);
        p_instr_valid = 1'b1;
        p_rs1         = a;
        p_rs2         = b;
        #1;
    endtask

    task automatic test_reset();
        p_reset = 1'b1;
        p_instr = '0; p_instr_valid = 1'b0;
        p_rs1 = '0; p_rs2 = '0; p_timeout_clr = 1'b0;
        p_fab_req_ready = '0; p_fab_rsp_valid = '0; p_fab_rsp_data = '0;
        tick(); tick();
        checks++;
        if ({p_fab_req_valid, p_stall, p_rd_we, p_timeout, p_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_ctl: got %b, need 0",
                     {p_fab_req_valid, p_stall, p_rd_we, p_timeout, p_illegal});
        end
        checks++;
        if (p_fab_rsp_ready !== 4'hF) begin
            errors++;
            $display("FAIL reset_rsp_ready: got %h need f", p_fab_rsp_ready);
        end
        checks++;
        if ({p_fab_op1, p_fab_op2, p_rd_data, p_fab_blocking} !== '0) begin
            errors++;
            $display("FAIL reset_data: op1=%h op2=%h rd_data=%h", p_fab_op1,
                     p_fab_op2, p_rd_data);
        end
        p_reset = 1'b0;
        tick();
    endtask

    task automatic test_blocking();
        p_fab_req_ready = '1;
        issue(7'd2, 3'b110, 5'd5, 32'h10, 32'h20);
        exp_q.push_back({5'd5, 32'h30});
        checks++;
        if ({p_is_efpga, p_stall, p_illegal} !== 3'b110) begin
            errors++;
            $display("FAIL blk_hit: got %b need 110",
                     {p_is_efpga, p_stall, p_illegal});
        end
        tick();
        p_instr_valid = 1'b0;
        checks++;
        if ({p_fab_req_valid, p_fab_blocking, p_stall} !== 6'b0100_11) begin
            errors++;
            $display("FAIL blk_issue: got %b need 010011",
                     {p_fab_req_valid, p_fab_blocking, p_stall});
        end
        checks++;
        if (p_fab_op1 !== 32'h10 || p_fab_op2 !== 32'h20) begin
            errors++;
            $display("FAIL blk_ops: got %h %h need 10 20", p_fab_op1, p_fab_op2);
        end
        tick();
        checks++;
        if ({p_fab_req_valid, p_fab_rsp_ready, p_stall} !== 9'b0000_0100_1) begin
            errors++;
            $display("FAIL blk_wait: got %b need 000001001",
                     {p_fab_req_valid, p_fab_rsp_ready, p_stall});
        end
        tick();
        p_fab_rsp_valid = 4'b0100;
        p_fab_rsp_data[2*XL +: XL] = 32'h30;
        tick();
        p_fab_rsp_valid = '0;
        #1;
        checks++;
        if ({p_stall, p_rd_we} !== 2'b01) begin
            errors++;
            $display("FAIL blk_done: stall/we got %b need 01", {p_stall, p_rd_we});
        end
        tick();
        checks++;
        if (p_rd_we !== 1'b0 || p_fab_rsp_ready !== 4'hF) begin
            errors++;
            $display("FAIL blk_idle: we=%b rsp_ready=%h need 0 f",
                     p_rd_we, p_fab_rsp_ready);
        end
    endtask

    task automatic test_posted();
        int n = 0;
        p_fab_req_ready = '0;
        issue(7'd1, 3'b111, 5'd7, 32'hA, 32'hB);
        tick();
        p_instr_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) p_fab_req_ready = '1;
            #1;
            n += int'(p_fab_req_valid[1]);
            if (k == 1) begin
                checks++;
                if (p_fab_blocking !== 1'b0) begin
                    errors++;
                    $display("FAIL post_blocking: got %b need 0", p_fab_blocking);
                end
            end
            tick();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL post_valid_cycles: got %0d need 4", n);
        end
        p_fab_rsp_valid = 4'b0010;
        #1;
        checks++;
        if ({p_stall, p_fab_rsp_ready} !== 5'b0_1111) begin
            errors++;
            $display("FAIL post_idle: got %b need 01111",
                     {p_stall, p_fab_rsp_ready});
        end
        tick();
        p_fab_rsp_valid = '0;
        n = 0;
        issue(7'd0, 3'b111, 5'd1, 32'h1, 32'h2);
        n += int'(p_stall);
        tick();
        p_instr_valid = 1'b0;
        #1;
        n += int'(p_stall);
        tick();
        n += int'(p_stall);
        tick();
        n += int'(p_stall);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL post_stall_cycles: got %0d need 2", n);
        end
    endtask

    task automatic test_illegal();
        issue(7'd4, 3'b110, 5'd3, 32'h1, 32'h1);
        checks++;
        if ({p_is_efpga, p_illegal, p_stall} !== 3'b110) begin
            errors++;
            $display("FAIL illegal_pulse: got %b need 110",
                     {p_is_efpga, p_illegal, p_stall});
        end
        tick();
        p_instr_valid = 1'b0;
        #1;
        checks++;
        if ({p_illegal, p_stall, p_fab_req_valid} !== '0) begin
            errors++;
            $display("FAIL illegal_after: got %b need 0",
                     {p_illegal, p_stall, p_fab_req_valid});
        end
    endtask

    task automatic test_timeout();
        logic ok = 1'b1;
        p_fab_req_ready = '0;
        issue(7'd3, 3'b110, 5'd9, 32'h3, 32'h4);
        exp_q.push_back({5'd9, 32'hFFFF_FFFF});
        tick();
        p_instr_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (p_stall !== 1'b1 || p_timeout !== 1'b0) ok = 1'b0;
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tmo_early: flag or stall wrong before 8 cycles");
        end
        checks++;
        if ({p_timeout, p_stall, p_fab_req_valid} !== 6'b10_0000) begin
            errors++;
            $display("FAIL tmo_set: got %b need 100000",
                     {p_timeout, p_stall, p_fab_req_valid});
        end
        tick();
        p_timeout_clr = 1'b1;
        tick();
        p_timeout_clr = 1'b0;
        checks++;
        if (p_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clr: got %b need 0", p_timeout);
        end
        p_fab_req_ready = '1;
    endtask

    task automatic test_rd_zero();
        issue(7'd0, 3'b110, 5'd0, 32'h7, 32'h8);
        tick();
        p_instr_valid = 1'b0;
        tick();
        p_fab_rsp_valid = 4'b0001;
        p_fab_rsp_data[0 +: XL] = 32'h55;
        #1;
        checks++;
        if (p_fab_rsp_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rd0_wait: rsp_ready got %b need 0001", p_fab_rsp_ready);
        end
        tick();
        p_fab_rsp_valid = '0;
        #1;
        checks++;
        if ({p_stall, p_rd_we} !== 2'b00) begin
            errors++;
            $display("FAIL rd0_done: got %b need 00", {p_stall, p_rd_we});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        issue(7'd2, 3'b110, 5'd6, 32'h66, 32'h77);
        tick();
        p_instr_valid = 1'b0;
        tick();
        p_reset = 1'b1;
        #1;
        checks++;
        if ({p_fab_req_valid, p_stall, p_rd_we} !== '0
            || p_fab_rsp_ready !== 4'hF) begin
            errors++;
            $display("FAIL mid_reset: req=%b stall=%b we=%b rsp_ready=%h",
                     p_fab_req_valid, p_stall, p_rd_we, p_fab_rsp_ready);
        end
        tick();
        p_reset = 1'b0;
        tick();
        issue(7'd1, 3'b110, 5'd4, 32'h1234, 32'h5678);
        exp_q.push_back({5'd4, 32'hABCD});
        tick();
        p_instr_valid = 1'b0;
        #1;
        checks++;
        if (p_fab_req_valid !== 4'b0010 || p_fab_op1 !== 32'h1234) begin
            errors++;
            $display("FAIL b2b_issue: req=%b op1=%h need 0010 1234",
                     p_fab_req_valid, p_fab_op1);
        end
        tick();
        p_fab_rsp_valid = 4'b0010;
        p_fab_rsp_data[1*XL +: XL] = 32'hABCD;
        tick();
        p_fab_rsp_valid = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_blocking();
        test_posted();
        test_illegal();
        test_timeout();
        test_rd_zero();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wb_missing: %0d writebacks left, need 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
